// File: rtl/ps2_move_decoder.sv
// Debounces the PS/2 scan-code level, maps held keys to 2048 moves and
// issues one command per physical keypress over a valid/ack handshake.
module ps2_move_decoder #(
  parameter int STABLE_CYCLES  = 250000,
  parameter int RELEASE_CYCLES = 250000,
  parameter int CNT_W          = 18
) (
  input  logic       i_clk25,
  input  logic       i_rst_n,
  input  logic [7:0] i_scan_code,
  input  logic       i_cmd_ack,
  output logic       o_cmd_valid,
  output logic [2:0] o_cmd,
  output logic       o_key_held,
  output logic [7:0] o_last_code
);

  // state   | meaning
  // IDLE    | no key, waiting for a nonzero code
  // QUALIFY | candidate code must stay unchanged for STABLE_CYCLES
  // FIRE    | one cycle: latch debug code, issue command if mapped
  // HOLD    | key down; other codes ignored until release
  // RELEASE | code must read zero for RELEASE_CYCLES
  typedef enum logic [2:0] {
    S_IDLE, S_QUALIFY, S_FIRE, S_HOLD, S_RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] STABLE_TC  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_TC = CNT_W'(RELEASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic             r_rst_meta, r_rst_sync;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [7:0]       r_code_q, r_cand, w_cand_nxt;
  logic [7:0]       r_last, w_last_nxt;
  logic [2:0]       r_cmd, w_cmd_nxt, w_map_cmd;
  logic             r_valid, w_valid_nxt;
  logic             r_held, w_held_nxt;
  logic             w_mapped;

  // Assert immediately, release two edges after rst_n rises
  always_ff @(posedge i_clk25 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  always_comb begin
    w_mapped  = 1'b1;
    w_map_cmd = 3'd0;
    case (r_cand)
      8'h1D, 8'h75: w_map_cmd = 3'd0;
      8'h1B, 8'h72: w_map_cmd = 3'd1;
      8'h1C, 8'h6B: w_map_cmd = 3'd2;
      8'h23, 8'h74: w_map_cmd = 3'd3;
      8'h2D:        w_map_cmd = 3'd4;
      default:      w_mapped  = 1'b0;
    endcase
  end

  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_last_nxt  = r_last;
    w_cmd_nxt   = r_cmd;
    w_valid_nxt = r_valid;
    w_held_nxt  = r_held;
    if (r_valid && i_cmd_ack) w_valid_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_code_q != 8'h00) begin
          w_cand_nxt  = r_code_q;
          w_cnt_nxt   = '0;
          w_state_nxt = S_QUALIFY;
        end
      end
      S_QUALIFY: begin
        if (r_code_q == 8'h00) begin
          w_state_nxt = S_IDLE;
        end else if (r_code_q != r_cand) begin
          w_cand_nxt = r_code_q;
          w_cnt_nxt  = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == STABLE_TC) w_state_nxt = S_FIRE;
        end
      end
      S_FIRE: begin
        w_last_nxt  = r_cand;
        w_held_nxt  = 1'b1;
        // A pending unacked command wins; the new press is dropped
        if (w_mapped && (!r_valid || i_cmd_ack)) begin
          w_cmd_nxt   = w_map_cmd;
          w_valid_nxt = 1'b1;
        end
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (r_code_q == 8'h00) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (r_code_q != 8'h00) begin
          w_state_nxt = S_HOLD;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == RELEASE_TC) begin
            w_held_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk25 or negedge r_rst_sync) begin
    if (!r_rst_sync) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_code_q <= 8'h00;
      r_cand   <= 8'h00;
      r_last   <= 8'h00;
      r_cmd    <= 3'd0;
      r_valid  <= 1'b0;
      r_held   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_code_q <= i_scan_code;
      r_cand   <= w_cand_nxt;
      r_last   <= w_last_nxt;
      r_cmd    <= w_cmd_nxt;
      r_valid  <= w_valid_nxt;
      r_held   <= w_held_nxt;
    end
  end

  assign o_cmd_valid = r_valid;
  assign o_cmd       = r_cmd;
  assign o_key_held  = r_held;
  assign o_last_code = r_last;

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Directed and randomized bench for ps2_move_decoder with short debounce
// windows; random phase is compared against a run-length reference model.
module tb_ps2_move_decoder;

  localparam int S = 4;
  localparam int R = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] scan;
  logic       ack;
  logic       o_cmd_valid;
  logic [2:0] o_cmd;
  logic       o_key_held;
  logic [7:0] o_last_code;

  int n_checks = 0;
  int n_fail   = 0;
  int rises    = 0;
  logic prev_valid = 1'b0;

  ps2_move_decoder #(.STABLE_CYCLES(S), .RELEASE_CYCLES(R), .CNT_W(18)) dut (
    .i_clk25(clk), .i_rst_n(rst_n), .i_scan_code(scan), .i_cmd_ack(ack),
    .o_cmd_valid(o_cmd_valid), .o_cmd(o_cmd), .o_key_held(o_key_held),
    .o_last_code(o_last_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_cmd_valid && !prev_valid) rises++;
    prev_valid = o_cmd_valid;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  // Reference model: press = S consecutive samples of one nonzero code,
  // release = R consecutive zero samples while held.
  logic [7:0] m_q, m_cand, m_last;
  logic [2:0] m_cmd;
  logic       m_valid, m_held, m_fire;
  int         m_run, m_zrun;

  function automatic logic [3:0] ref_map(input logic [7:0] c);
    case (c)
      8'h1D, 8'h75: return 4'b1_000;
      8'h1B, 8'h72: return 4'b1_001;
      8'h1C, 8'h6B: return 4'b1_010;
      8'h23, 8'h74: return 4'b1_011;
      8'h2D:        return 4'b1_100;
      default:      return 4'b0_000;
    endcase
  endfunction

  task automatic model_reset();
    m_q = 8'h00; m_cand = 8'h00; m_last = 8'h00; m_cmd = 3'd0;
    m_valid = 1'b0; m_held = 1'b0; m_fire = 1'b0; m_run = 0; m_zrun = 0;
  endtask

  task automatic model_step(input logic a, input logic [7:0] sc);
    logic [3:0] mp;
    logic [7:0] c;
    c = m_q;
    if (m_fire) begin
      m_fire = 1'b0;
      m_held = 1'b1;
      m_last = m_cand;
      m_zrun = 0;
      mp = ref_map(m_cand);
      if (mp[3] && (!m_valid || a)) begin
        m_cmd = mp[2:0];
        m_valid = 1'b1;
      end else if (a) m_valid = 1'b0;
    end else begin
      if (a) m_valid = 1'b0;
      if (!m_held) begin
        if (c == 8'h00) m_run = 0;
        else if (m_run > 0 && c == m_cand) m_run++;
        else begin m_cand = c; m_run = 1; end
        if (m_run == S) begin m_fire = 1'b1; m_run = 0; end
      end else if (c == 8'h00) begin
        m_zrun++;
        if (m_zrun == R) begin m_held = 1'b0; m_zrun = 0; m_run = 0; end
      end else m_zrun = 0;
    end
    m_q = sc;
  endtask

  initial begin
    int r0;
    int seg_left;
    logic [7:0] seg_val;
    logic [7:0] pool [12];
    pool = '{8'h00, 8'h1D, 8'h75, 8'h1B, 8'h72, 8'h1C,
             8'h6B, 8'h23, 8'h74, 8'h2D, 8'h5A, 8'h00};

    // Reset with a key already held
    rst_n = 1'b0; scan = 8'h1D; ack = 1'b0;
    tick(3);
    check("rst_valid", {7'd0, o_cmd_valid}, 8'd0);
    check("rst_cmd", {5'd0, o_cmd}, 8'd0);
    check("rst_held", {7'd0, o_key_held}, 8'd0);
    check("rst_last", o_last_code, 8'h00);
    rst_n = 1'b1;
    tick(7);
    check("rst_early_valid", {7'd0, o_cmd_valid}, 8'd0);
    tick(1);
    check("rst_first_valid", {7'd0, o_cmd_valid}, 8'd1);
    check("rst_first_cmd", {5'd0, o_cmd}, 8'd0);
    ack_pulse();
    scan = 8'h00;
    tick(8);
    check("rst_released", {7'd0, o_key_held}, 8'd0);

    // Single press, exact latency
    r0 = rises;
    scan = 8'h75;
    tick(5);
    check("press_not_yet", {7'd0, o_cmd_valid}, 8'd0);
    tick(1);
    check("press_valid", {7'd0, o_cmd_valid}, 8'd1);
    check("press_cmd", {5'd0, o_cmd}, 8'd0);
    tick(2);
    ack_pulse();
    check("press_ack_clear", {7'd0, o_cmd_valid}, 8'd0);
    tick(11);
    check("press_held", {7'd0, o_key_held}, 8'd1);
    check("press_last", o_last_code, 8'h75);
    scan = 8'h00;
    tick(4);
    check("release_not_yet", {7'd0, o_key_held}, 8'd1);
    tick(1);
    check("release_time", {7'd0, o_key_held}, 8'd0);
    tick(2);
    check("press_one_cmd", 8'(rises - r0), 8'd1);

    // Glitch rejection and candidate reload
    r0 = rises;
    scan = 8'h1C; tick(3);
    scan = 8'h00; tick(1);
    scan = 8'h1C; tick(3);
    scan = 8'h00; tick(6);
    check("glitch_held", {7'd0, o_key_held}, 8'd0);
    check("glitch_no_cmd", 8'(rises - r0), 8'd0);
    scan = 8'h1C; tick(2);
    scan = 8'h23; tick(8);
    check("reload_valid", {7'd0, o_cmd_valid}, 8'd1);
    check("reload_cmd", {5'd0, o_cmd}, 8'd3);
    check("reload_last", o_last_code, 8'h23);
    ack_pulse();
    scan = 8'h00; tick(8);
    check("reload_one_cmd", 8'(rises - r0), 8'd1);

    // Release bounce
    r0 = rises;
    scan = 8'h6B; tick(8);
    check("bounce_cmd", {5'd0, o_cmd}, 8'd2);
    ack_pulse();
    scan = 8'h00; tick(2);
    scan = 8'h6B; tick(4);
    check("bounce_still_held", {7'd0, o_key_held}, 8'd1);
    scan = 8'h00; tick(10);
    check("bounce_released", {7'd0, o_key_held}, 8'd0);
    check("bounce_one_cmd", 8'(rises - r0), 8'd1);

    // Pending command: dropped without ack, replaced with ack in FIRE
    r0 = rises;
    scan = 8'h1B; tick(8);
    check("pend_first_cmd", {5'd0, o_cmd}, 8'd1);
    scan = 8'h00; tick(8);
    scan = 8'h2D; tick(8);
    check("pend_drop_valid", {7'd0, o_cmd_valid}, 8'd1);
    check("pend_drop_cmd", {5'd0, o_cmd}, 8'd1);
    check("pend_drop_last", o_last_code, 8'h2D);
    scan = 8'h00; tick(8);
    scan = 8'h2D; tick(5);
    ack = 1'b1; tick(1); ack = 1'b0;
    check("fire_ack_valid", {7'd0, o_cmd_valid}, 8'd1);
    check("fire_ack_cmd", {5'd0, o_cmd}, 8'd4);
    tick(2);
    check("fire_ack_no_gap", 8'(rises - r0), 8'd1);
    ack_pulse();
    check("fire_ack_clear", {7'd0, o_cmd_valid}, 8'd0);
    scan = 8'h00; tick(8);

    // Unmapped key then asynchronous reset mid-hold
    r0 = rises;
    scan = 8'h5A; tick(8);
    check("unmapped_last", o_last_code, 8'h5A);
    check("unmapped_held", {7'd0, o_key_held}, 8'd1);
    check("unmapped_no_valid", {7'd0, o_cmd_valid}, 8'd0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_held", {7'd0, o_key_held}, 8'd0);
    check("async_last", o_last_code, 8'h00);
    check("async_cmd", {5'd0, o_cmd}, 8'd0);
    check("async_valid", {7'd0, o_cmd_valid}, 8'd0);

    // Randomized traffic against the reference model
    scan = 8'h00;
    tick(1);
    rst_n = 1'b1;
    tick(4);
    model_reset();
    seg_left = 0;
    seg_val = 8'h00;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      if (seg_left == 0) begin
        seg_val  = pool[$urandom_range(0, 11)];
        seg_left = $urandom_range(1, 9);
      end
      scan = seg_val;
      seg_left--;
      ack = ($urandom_range(0, 3) == 0);
      @(posedge clk);
      model_step(ack, scan);
      #1;
      check("rand_valid", {7'd0, o_cmd_valid}, {7'd0, m_valid});
      check("rand_cmd", {5'd0, o_cmd}, {5'd0, m_cmd});
      check("rand_held", {7'd0, o_key_held}, {7'd0, m_held});
      check("rand_last", o_last_code, m_last);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
